ctrl_pipe: RTL and testbench

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pipe.sv | 183 ++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// Five-stage control pipeline: carries decode controls ID->EX->WB (1/2/3 edges) and resolves hazards.
// Load-use stall holds PC and IF/ID for one cycle and inserts an all-zero bubble; no other backpressure.
module ctrl_pipe #(
    parameter bit FLUSH_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [11:0] id_ctrl,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] id_rd,
    output logic [8:0] ex_ctrl,
    output logic [3:0] mem_ctrl,
    output logic [1:0] wb_ctrl,
    output logic [4:0] ex_dst,
    output logic [4:0] mem_dst,
    output logic [4:0] wb_dst,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       if_flush,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    typedef struct packed {
        logic       regdst;
        logic       regwrite;
        logic       jal;
        logic       jr;
        logic       jmp;
        logic       memtoreg;
        logic       memread;
        logic       memwrite;
        logic       alusrc;
        logic       pcsrc;
        logic [1:0] aluop;
    } id_ctrl_t;

    typedef struct packed {
        logic       regdst;
        logic       regwrite;
        logic       jal;
        logic       memtoreg;
        logic       memread;
        logic       memwrite;
        logic       alusrc;
        logic [1:0] aluop;
    } ex_ctrl_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memread;
        logic memwrite;
    } mem_ctrl_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } wb_ctrl_t;

    localparam logic [4:0] LINK_REG = 5'd31;
    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] FWD_WB   = 2'b01;

    id_ctrl_t  id_c;
    ex_ctrl_t  ex_d;
    ex_ctrl_t  ex_q;
    mem_ctrl_t mem_q;
    wb_ctrl_t  wb_q;

    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic [4:0] ex_rd;
    logic [4:0] ex_dst_w;
    logic [4:0] mem_dst_q;
    logic [4:0] wb_dst_q;
    logic       stall;
    logic       ctrl_xfer;

    assign id_c = id_ctrl_t'(id_ctrl);

    always_comb begin
        if (ex_q.jal)
            ex_dst_w = LINK_REG;
        else if (ex_q.regdst)
            ex_dst_w = ex_rd;
        else
            ex_dst_w = ex_rt;
    end

    // r0 is never a real producer, so it can neither stall nor forward.
    assign stall = ex_q.memread && (ex_dst_w != 5'd0) &&
                   ((ex_dst_w == id_rs) || (ex_dst_w == id_rt));

    always_comb begin
        ex_d = '{
            regdst:   id_c.regdst,
            regwrite: id_c.regwrite,
            jal:      id_c.jal,
            memtoreg: id_c.memtoreg,
            memread:  id_c.memread,
            memwrite: id_c.memwrite,
            alusrc:   id_c.alusrc,
            aluop:    id_c.aluop
        };
        if (stall)
            ex_d = '0;
    end

    // ID/EX: register fields load even on a bubble; only the controls are zeroed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            ex_rs <= '0;
            ex_rt <= '0;
            ex_rd <= '0;
        end else begin
            ex_q  <= ex_d;
            ex_rs <= id_rs;
            ex_rt <= id_rt;
            ex_rd <= id_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q     <= '0;
            mem_dst_q <= '0;
        end else begin
            mem_q     <= '{
                regwrite: ex_q.regwrite,
                memtoreg: ex_q.memtoreg,
                memread:  ex_q.memread,
                memwrite: ex_q.memwrite
            };
            mem_dst_q <= ex_dst_w;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q     <= '0;
            wb_dst_q <= '0;
        end else begin
            wb_q     <= '{regwrite: mem_q.regwrite, memtoreg: mem_q.memtoreg};
            wb_dst_q <= mem_dst_q;
        end
    end

    // The younger producer (EX/MEM) holds the newest value, so it is checked first.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       mem_wr,
        input logic [4:0] mem_d,
        input logic       wb_wr,
        input logic [4:0] wb_d
    );
        if (mem_wr && (mem_d != 5'd0) && (mem_d == src))
            return FWD_MEM;
        else if (wb_wr && (wb_d != 5'd0) && (wb_d == src))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    assign fwd_a = fwd_sel(ex_rs, mem_q.regwrite, mem_dst_q, wb_q.regwrite, wb_dst_q);
    assign fwd_b = fwd_sel(ex_rt, mem_q.regwrite, mem_dst_q, wb_q.regwrite, wb_dst_q);

    assign ctrl_xfer  = id_c.pcsrc || id_c.jmp || id_c.jr;
    assign if_flush   = FLUSH_EN && !stall && ctrl_xfer;
    assign pc_write   = !stall;
    assign ifid_write = !stall;

    assign ex_ctrl  = ex_q;
    assign mem_ctrl = mem_q;
    assign wb_ctrl  = wb_q;
    assign ex_dst   = ex_dst_w;
    assign mem_dst  = mem_dst_q;
    assign wb_dst   = wb_dst_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: hazards, forwarding, flush (both FLUSH_EN settings), JAL and async reset.
module tb_ctrl_pipe;

    localparam logic [11:0] C_RTYPE = 12'hC02;
    localparam logic [11:0] C_LW    = 12'h469;
    localparam logic [11:0] C_BEQ   = 12'h005;
    localparam logic [11:0] C_JAL   = 12'h680;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] id_ctrl = '0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic [4:0]  id_rd = '0;

    logic [8:0] ex_ctrl;
    logic [3:0] mem_ctrl;
    logic [1:0] wb_ctrl;
    logic [4:0] ex_dst, mem_dst, wb_dst;
    logic       pc_write, ifid_write, if_flush;
    logic [1:0] fwd_a, fwd_b;

    logic [8:0] n_ex_ctrl;
    logic [3:0] n_mem_ctrl;
    logic [1:0] n_wb_ctrl;
    logic [4:0] n_ex_dst, n_mem_dst, n_wb_dst;
    logic       n_pc_write, n_ifid_write, n_if_flush;
    logic [1:0] n_fwd_a, n_fwd_b;

    int compared = 0;
    int mismatched = 0;

    ctrl_pipe #(.FLUSH_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .id_ctrl(id_ctrl), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
        .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
        .pc_write(pc_write), .ifid_write(ifid_write), .if_flush(if_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    ctrl_pipe #(.FLUSH_EN(1'b0)) dut_nf (
        .clk(clk), .rst(rst), .id_ctrl(id_ctrl), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_ctrl(n_ex_ctrl), .mem_ctrl(n_mem_ctrl), .wb_ctrl(n_wb_ctrl),
        .ex_dst(n_ex_dst), .mem_dst(n_mem_dst), .wb_dst(n_wb_dst),
        .pc_write(n_pc_write), .ifid_write(n_ifid_write), .if_flush(n_if_flush),
        .fwd_a(n_fwd_a), .fwd_b(n_fwd_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [11:0] c, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd);
        id_ctrl = c;
        id_rs   = rs;
        id_rt   = rt;
        id_rd   = rd;
        #1;
    endtask

    initial begin
        // Reset state, with a branch in ID so if_flush follows id_ctrl.
        set_id(C_BEQ, 5'd0, 5'd0, 5'd0);
        rst = 1'b1;
        #1;
        chk("rst_ex_ctrl",  16'(ex_ctrl), 16'h000);
        chk("rst_mem_ctrl", 16'(mem_ctrl), 16'h0);
        chk("rst_wb_ctrl",  16'(wb_ctrl), 16'h0);
        chk("rst_ex_dst",   16'(ex_dst), 16'd0);
        chk("rst_fwd",      16'({fwd_a, fwd_b}), 16'h0);
        chk("rst_pcw",      16'({pc_write, ifid_write}), 16'h3);
        chk("rst_flush",    16'(if_flush), 16'h1);
        chk("rst_flush_nf", 16'(n_if_flush), 16'h0);
        tick();
        tick();
        rst = 1'b0;
        set_id(12'h000, 5'd0, 5'd0, 5'd0);
        tick();

        // Load-use: LW rt=5, consumer rs=5.
        set_id(C_LW, 5'd1, 5'd5, 5'd0);
        tick();
        set_id(C_RTYPE, 5'd5, 5'd2, 5'd3);
        chk("lu_ex_ctrl", 16'(ex_ctrl), 16'h0B5);
        chk("lu_ex_dst",  16'(ex_dst), 16'd5);
        chk("lu_stall",   16'({pc_write, ifid_write}), 16'h0);
        chk("lu_flush",   16'(if_flush), 16'h0);
        tick();
        chk("lu_bubble",   16'(ex_ctrl), 16'h000);
        chk("lu_release",  16'({pc_write, ifid_write}), 16'h3);
        chk("lu_mem_ctrl", 16'(mem_ctrl), 16'hE);
        chk("lu_mem_dst",  16'(mem_dst), 16'd5);
        tick();
        chk("lu_cons_ex",  16'(ex_ctrl), 16'h182);
        chk("lu_cons_dst", 16'(ex_dst), 16'd3);
        chk("lu_bub_mem",  16'(mem_ctrl), 16'h0);
        chk("lu_wb_ctrl",  16'(wb_ctrl), 16'h3);
        chk("lu_fwd_a",    16'(fwd_a), 16'h1);
        chk("lu_fwd_b",    16'(fwd_b), 16'h0);

        // EX/MEM then MEM/WB forwarding of r7.
        set_id(C_RTYPE, 5'd1, 5'd2, 5'd7);
        tick();
        set_id(C_RTYPE, 5'd7, 5'd4, 5'd8);
        tick();
        chk("exfwd_a", 16'(fwd_a), 16'h2);
        chk("exfwd_b", 16'(fwd_b), 16'h0);
        set_id(C_RTYPE, 5'd3, 5'd7, 5'd9);
        tick();
        chk("wbfwd_b", 16'(fwd_b), 16'h1);
        chk("wbfwd_a", 16'(fwd_a), 16'h0);

        // Two writers of r9: the younger one wins.
        set_id(C_RTYPE, 5'd0, 5'd0, 5'd9);
        tick();
        set_id(C_RTYPE, 5'd0, 5'd0, 5'd9);
        tick();
        set_id(C_RTYPE, 5'd9, 5'd9, 5'd1);
        tick();
        chk("prio_a", 16'(fwd_a), 16'h2);
        chk("prio_b", 16'(fwd_b), 16'h2);

        // r0 never forwards nor stalls.
        set_id(C_RTYPE, 5'd1, 5'd2, 5'd0);
        tick();
        set_id(C_RTYPE, 5'd0, 5'd0, 5'd4);
        tick();
        chk("r0_fwd", 16'({fwd_a, fwd_b}), 16'h0);
        set_id(C_LW, 5'd1, 5'd0, 5'd0);
        tick();
        set_id(C_RTYPE, 5'd0, 5'd0, 5'd5);
        chk("r0_lw_ex",   16'(ex_ctrl), 16'h0B5);
        chk("r0_nostall", 16'({pc_write, ifid_write}), 16'h3);
        tick();

        // Branch flush, then branch colliding with a load-use stall.
        set_id(C_BEQ, 5'd6, 5'd6, 5'd0);
        chk("beq_flush",    16'(if_flush), 16'h1);
        chk("beq_flush_nf", 16'(n_if_flush), 16'h0);
        chk("beq_pcw",      16'(pc_write), 16'h1);
        set_id(C_LW, 5'd1, 5'd6, 5'd0);
        tick();
        set_id(C_BEQ, 5'd6, 5'd0, 5'd0);
        chk("beqst_flush", 16'(if_flush), 16'h0);
        chk("beqst_pcw",   16'(pc_write), 16'h0);
        tick();
        chk("beqst_flush2",    16'(if_flush), 16'h1);
        chk("beqst_flush2_nf", 16'(n_if_flush), 16'h0);
        chk("beqst_pcw2",      16'(pc_write), 16'h1);

        // JAL writes r31 through to WB.
        set_id(C_JAL, 5'd2, 5'd3, 5'd4);
        chk("jal_flush", 16'(if_flush), 16'h1);
        tick();
        chk("jal_ex_ctrl", 16'(ex_ctrl), 16'h0C0);
        chk("jal_ex_dst",  16'(ex_dst), 16'd31);
        set_id(C_RTYPE, 5'd1, 5'd1, 5'd4);
        tick();
        chk("jal_mem_dst",  16'(mem_dst), 16'd31);
        chk("jal_mem_ctrl", 16'(mem_ctrl), 16'h8);
        set_id(12'h000, 5'd0, 5'd0, 5'd0);
        tick();
        chk("jal_wb_dst",  16'(wb_dst), 16'd31);
        chk("jal_wb_ctrl", 16'(wb_ctrl), 16'h2);

        // Async reset in the middle of a load-use stall with a branch waiting.
        set_id(C_LW, 5'd1, 5'd3, 5'd0);
        tick();
        set_id(C_BEQ, 5'd3, 5'd0, 5'd0);
        chk("pre_rst_pcw",   16'(pc_write), 16'h0);
        chk("pre_rst_flush", 16'(if_flush), 16'h0);
        chk("pre_rst_wb",    16'(wb_ctrl), 16'h2);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_ex_ctrl",  16'(ex_ctrl), 16'h000);
        chk("arst_mem_ctrl", 16'(mem_ctrl), 16'h0);
        chk("arst_wb_ctrl",  16'(wb_ctrl), 16'h0);
        chk("arst_dsts",     16'({ex_dst, mem_dst, wb_dst}), 16'h0);
        chk("arst_fwd",      16'({fwd_a, fwd_b}), 16'h0);
        chk("arst_pcw",      16'({pc_write, ifid_write}), 16'h3);
        chk("arst_flush",    16'(if_flush), 16'h1);
        tick();
        rst = 1'b0;
        set_id(12'h000, 5'd0, 5'd0, 5'd0);
        tick();
        chk("post_rst_ex", 16'(ex_ctrl), 16'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
